sc_mul_rot_seq: RTL and testbench

SC_MUL_ROT_SEQ -- requirements
Module: sc_mul_rot_seq

---
 rtl/sc_mul_rot_seq.sv | 146 ++++++++++++++
 tb/tb_sc_mul_rot_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_mul_rot_seq.sv
// Stochastic-computing unipolar multiplier: two LFSR streams with rotation pair every A value with every B value once.
// Optional abort input is compiled in when SC_MUL_ABORT_EN is defined.
module sc_mul_rot_seq #(
    parameter int                DATAWD = 8,
    parameter logic [DATAWD-1:0] SEED_A = {DATAWD{1'b1}},
    parameter logic [DATAWD-1:0] SEED_B = {DATAWD{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATAWD-1:0]     iA,
    input  logic [DATAWD-1:0]     iB,
    input  logic                  start,
`ifdef SC_MUL_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATAWD-1:0]   oC
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Feedback tap mask, bit (t-1) set for tap position t of the maximal-length polynomial.
    function automatic logic [9:0] tap_mask(input int width);
        logic [9:0] m;
        case (width)
            4:       m = 10'h00C;
            5:       m = 10'h014;
            6:       m = 10'h030;
            7:       m = 10'h060;
            8:       m = 10'h0B8;
            9:       m = 10'h110;
            10:      m = 10'h240;
            default: m = 10'h00C;
        endcase
        return m;
    endfunction

    localparam logic [9:0] TAPS = tap_mask(DATAWD);

    function automatic logic [DATAWD-1:0] lfsr_step(input logic [DATAWD-1:0] v);
        logic fb;
        fb = ^(v & TAPS[DATAWD-1:0]);
        return {v[DATAWD-2:0], fb};
    endfunction

    logic [1:0]          state_r;
    logic [DATAWD-1:0]   buf_a_r;
    logic [DATAWD-1:0]   buf_b_r;
    logic [DATAWD-1:0]   lfsr_a_r;
    logic [DATAWD-1:0]   lfsr_b_r;

    logic [DATAWD-1:0]   lfsr_a_nxt_s;
    logic [DATAWD-1:0]   lfsr_b_nxt_s;
    logic                a_wrap_s;
    logic                last_s;
    logic                hit_s;
    logic                abort_s;
    logic [2*DATAWD-1:0] inc_s;

    // Stream compare and end-of-run detection; the run ends when both streams wrap together.
    always_comb begin
        lfsr_a_nxt_s = lfsr_step(lfsr_a_r);
        lfsr_b_nxt_s = lfsr_step(lfsr_b_r);
        a_wrap_s     = (lfsr_a_nxt_s == SEED_A);
        last_s       = a_wrap_s && (lfsr_b_nxt_s == SEED_B);
        hit_s        = (buf_a_r > lfsr_a_r) && (buf_b_r > lfsr_b_r);
        inc_s        = {{(2*DATAWD-1){1'b0}}, hit_s};
`ifdef SC_MUL_ABORT_EN
        abort_s      = abort;
`else
        abort_s      = 1'b0;
`endif
    end

    // Control FSM, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            buf_a_r  <= {DATAWD{1'b0}};
            buf_b_r  <= {DATAWD{1'b0}};
            lfsr_a_r <= SEED_A;
            lfsr_b_r <= SEED_B;
            oC       <= {(2*DATAWD){1'b0}};
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r  <= ST_RUN;
                        buf_a_r  <= iA;
                        buf_b_r  <= iB;
                        lfsr_a_r <= SEED_A;
                        lfsr_b_r <= SEED_B;
                        oC       <= {(2*DATAWD){1'b0}};
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end else begin
                        state_r  <= ST_IDLE;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    oC       <= oC + inc_s;
                    lfsr_a_r <= lfsr_a_nxt_s;
                    if (a_wrap_s) begin
                        lfsr_b_r <= lfsr_b_nxt_s;
                    end else begin
                        lfsr_b_r <= lfsr_b_r;
                    end
                    if (abort_s) begin
                        state_r <= ST_IDLE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (last_s) begin
                        state_r <= ST_DONE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mul_rot_seq.sv
// Randomized self-checking bench for sc_mul_rot_seq against a pairing/arithmetic reference model.
// Exercises the abort port when SC_MUL_ABORT_EN is defined.
module tb_sc_mul_rot_seq;

    localparam int         W  = 6;
    localparam int         P  = (1 << W) - 1;
    localparam logic [W-1:0] SA = 6'h2D;
    localparam logic [W-1:0] SB = 6'h13;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   ia;
    logic [W-1:0]   ib;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] oc;
`ifdef SC_MUL_ABORT_EN
    logic           abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int seq_a[P];
    int seq_b[P];

    sc_mul_rot_seq #(.DATAWD(W), .SEED_A(SA), .SEED_B(SB)) dut (
        .clk   (clk),
        .rst   (rst),
        .iA    (ia),
        .iB    (ib),
        .start (start),
`ifdef SC_MUL_ABORT_EN
        .abort (abort),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .oC    (oc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Next value of a W-bit Fibonacci LFSR with the listed taps, shifting toward the MSB.
    function automatic int lfsr_next(input int v);
        int mask;
        int fb;
        case (W)
            4: mask = 'h00C;  5: mask = 'h014;  6: mask = 'h030;  7: mask = 'h060;
            8: mask = 'h0B8;  9: mask = 'h110;  10: mask = 'h240;
            default: mask = 'h00C;
        endcase
        fb = $countones(v & mask) % 2;
        return ((v << 1) | fb) & P;
    endfunction

    function automatic int expect_prod(input int a, input int b);
        int aa = (a == 0) ? 1 : a;
        int bb = (b == 0) ? 1 : b;
        return (aa - 1) * (bb - 1);
    endfunction

    // Count after k RUN cycles: cycle t pairs A-stream value t%P with B-stream value t/P.
    function automatic int partial(input int a, input int b, input int k);
        int cnt = 0;
        for (int t = 0; t < k; t++)
            if (a > seq_a[t % P] && b > seq_b[t / P]) cnt++;
        return cnt;
    endfunction

    task automatic start_op(input int a, input int b, input bit hold);
        @(negedge clk);
        ia = W'(a);
        ib = W'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_run(input int a, input int b, input bit spam, input int check_at,
                            output int cycles, output int dones);
        cycles = 0;
        dones  = 0;
        while (busy === 1'b1 && cycles < P * P + 10) begin
            if (cycles == check_at) check("partial", oc, partial(a, b, check_at));
            if (done === 1'b1) dones++;
            cycles++;
            @(negedge clk);
            if (spam) begin
                start = 1'b1;
                ia = W'($urandom);
                ib = W'($urandom);
            end
            @(posedge clk);
            #1;
        end
        if (spam) start = 1'b0;
        if (done === 1'b1) dones++;
    endtask

    task automatic run_check(input int a, input int b, input bit spam, input int check_at);
        int cycles;
        int dones;
        start_op(a, b, 1'b0);
        wait_run(a, b, spam, check_at, cycles, dones);
        check("busy_cycles", cycles, P * P);
        check("done_count", dones, 1);
        check("product", oc, expect_prod(a, b));
        @(posedge clk);
        #1;
        check("idle_after_done", {ready, busy, done}, 3'b100);
        check("hold_result", oc, expect_prod(a, b));
    endtask

    initial begin
        int v;
        int cycles;
        int dones;
        int saw_done;
        v = SA;
        for (int i = 0; i < P; i++) begin seq_a[i] = v; v = lfsr_next(v); end
        v = SB;
        for (int i = 0; i < P; i++) begin seq_b[i] = v; v = lfsr_next(v); end

        rst = 1'b1; start = 1'b0; ia = '0; ib = '0;
`ifdef SC_MUL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", {ready, busy, done}, 3'b100);
        check("reset_oc", oc, 0);
        rst = 1'b0;

        run_check(63, 63, 1'b0, 1000);
        run_check(0, 50, 1'b0, -1);
        run_check(32, 16, 1'b0, 70);
        run_check(45, 30, 1'b1, 500);
        for (int r = 0; r < 4; r++)
            run_check($urandom_range(0, P), $urandom_range(0, P), 1'b0, $urandom_range(1, P * P - 1));

        // Reset in mid-run: count discarded, no done, next run clean.
        start_op(40, 40, 1'b0);
        saw_done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_status", {ready, busy, done}, 3'b100);
        check("rst_mid_oc", oc, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done++;
        end
        check("rst_no_done", saw_done, 0);
        run_check(40, 40, 1'b0, -1);

        // Start held through DONE: back-to-back runs without an IDLE cycle.
        start_op(10, 20, 1'b1);
        wait_run(10, 20, 1'b0, -1, cycles, dones);
        check("held_done", done, 1'b1);
        check("held_oc1", oc, 171);
        @(posedge clk);
        #1;
        check("held_rerun", {ready, busy, done}, 3'b010);
        start = 1'b0;
        wait_run(10, 20, 1'b0, 10, cycles, dones);
        check("held_cycles2", cycles, P * P);
        check("held_oc2", oc, 171);

`ifdef SC_MUL_ABORT_EN
        start_op(50, 33, 1'b0);
        repeat (99) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_status", {ready, busy, done}, 3'b100);
        check("abort_oc", oc, partial(50, 33, 100));
        @(negedge clk);
        abort = 1'b1; start = 1'b1; ia = W'(7); ib = W'(9);
        @(posedge clk);
        #1;
        abort = 1'b0; start = 1'b0;
        check("abort_idle_ignored", busy, 1'b1);
        wait_run(7, 9, 1'b0, -1, cycles, dones);
        check("abort_after_cycles", cycles, P * P);
        check("abort_after_oc", oc, expect_prod(7, 9));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
